// File: rtl/d5m_frame_gen.sv
// d5m_frame_gen: D5M camera emulator producing frame-valid / line-valid /
// pixel-data timing with a selectable test pattern.
//
// Optional feature: define D5M_FRAME_GEN_LFSR_EN to build the 16-bit LFSR
// pattern (pattern_sel = 3). Without it, pattern 3 drives zero pixels.
//
// Every output is a register loaded from the current FSM state and
// counters. As a result, outputs trail the state by one pixel clock.
`timescale 1ns/1ps

module d5m_frame_gen #(
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 4,
    parameter int DATA_WIDTH = 12,
    parameter int H_BLANK    = 3,
    parameter int V_BLANK    = 5,
    parameter int FV_LEAD    = 2
) (
    input  logic                  pixclk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [1:0]            pattern_sel,
    output logic                  ifval,
    output logic                  ilval,
    output logic [DATA_WIDTH-1:0] idata,
    output logic [15:0]           frame_count,
    output logic                  busy
);

    // Phase and line counters are wide enough for any supported pixel width.
    localparam int CW = 16;

    localparam logic [CW-1:0] ONE       = CW'(1);
    localparam logic [CW-1:0] LEAD_LAST = CW'(FV_LEAD - 1);
    localparam logic [CW-1:0] X_LAST    = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0] HB_LAST   = CW'(H_BLANK - 1);
    localparam logic [CW-1:0] Y_LAST    = CW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] VB_LAST   = CW'(V_BLANK - 1);

    // Bayer GRBG levels: green at mid-scale (MSB only), red full, blue zero.
    localparam logic [DATA_WIDTH-1:0] PIX_G = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] PIX_R = {DATA_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] PIX_B = {DATA_WIDTH{1'b0}};

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        VLEAD  = 3'd1,
        LINE   = 3'd2,
        HBLANK = 3'd3,
        VBLANK = 3'd4
    } state_t;

    state_t                state;
    logic [CW-1:0]         cnt;        // cycle count in the current state; x while in LINE
    logic [CW-1:0]         y;          // active line index within the frame
    logic [1:0]            pat;        // pattern latched for the frame in progress
    logic                  frame_start;
    logic [DATA_WIDTH-1:0] lfsr_pix;

    // Bayer GRBG mosaic selected by row and column parity.
    function automatic logic [DATA_WIDTH-1:0] bayer_value(input logic row_odd,
                                                          input logic col_odd);
        logic [DATA_WIDTH-1:0] v;
        case ({row_odd, col_odd})
            2'b00:   v = PIX_G;
            2'b01:   v = PIX_R;
            2'b10:   v = PIX_B;
            default: v = PIX_G;
        endcase
        return v;
    endfunction

    // Pixel value for one active position; rnd carries the LFSR sample.
    function automatic logic [DATA_WIDTH-1:0] pixel_value(input logic [1:0]            sel,
                                                          input logic [DATA_WIDTH-1:0] x_lo,
                                                          input logic [DATA_WIDTH-1:0] y_lo,
                                                          input logic [DATA_WIDTH-1:0] rnd);
        logic [DATA_WIDTH-1:0] v;
        case (sel)
            2'd0:    v = x_lo;
            2'd1:    v = y_lo;
            2'd2:    v = bayer_value(y_lo[0], x_lo[0]);
            default: v = rnd;
        endcase
        return v;
    endfunction

    // A new frame begins from IDLE or at the end of VBLANK, gated by enable.
    assign frame_start = enable && ((state == IDLE) ||
                                    ((state == VBLANK) && (cnt == VB_LAST)));

`ifdef D5M_FRAME_GEN_LFSR_EN
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    logic [15:0] lfsr;

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting right with feedback into bit 15.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    // Reseed at every frame start and advance once per active pixel.
    always_ff @(posedge pixclk or posedge reset) begin
        if (reset) begin
            lfsr <= LFSR_SEED;
        end else if (frame_start) begin
            lfsr <= LFSR_SEED;
        end else if (state == LINE) begin
            lfsr <= lfsr_step(lfsr);
        end
    end

    // The current LFSR value feeds the pixel, so the first pixel is the seed.
    assign lfsr_pix = lfsr[DATA_WIDTH-1:0];
`else
    assign lfsr_pix = '0;
`endif

    // Frame FSM plus registered timing and pixel outputs.
    always_ff @(posedge pixclk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            y           <= '0;
            pat         <= 2'd0;
            ifval       <= 1'b0;
            ilval       <= 1'b0;
            idata       <= '0;
            frame_count <= 16'd0;
            busy        <= 1'b0;
        end else begin
            ifval <= (state == VLEAD) || (state == LINE) || (state == HBLANK);
            ilval <= (state == LINE);
            busy  <= (state != IDLE);

            if (state == LINE) begin
                idata <= pixel_value(pat, cnt[DATA_WIDTH-1:0], y[DATA_WIDTH-1:0], lfsr_pix);
            end else begin
                idata <= '0;
            end

            // ifval is still high on the first VBLANK cycle: this edge is its fall.
            if ((state == VBLANK) && ifval) begin
                frame_count <= frame_count + 16'd1;
            end

            if (frame_start) begin
                pat <= pattern_sel;
                y   <= '0;
            end

            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= VLEAD;
                        cnt   <= '0;
                    end
                end
                VLEAD: begin
                    if (cnt == LEAD_LAST) begin
                        state <= LINE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                LINE: begin
                    if (cnt == X_LAST) begin
                        state <= HBLANK;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                HBLANK: begin
                    if (cnt == HB_LAST) begin
                        cnt <= '0;
                        if (y == Y_LAST) begin
                            state <= VBLANK;
                        end else begin
                            y     <= y + ONE;
                            state <= LINE;
                        end
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                VBLANK: begin
                    if (cnt == VB_LAST) begin
                        cnt   <= '0;
                        state <= enable ? VLEAD : IDLE;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_d5m_frame_gen.sv
// tb_d5m_frame_gen: directed bench for d5m_frame_gen with a frame-position
// reference model. Follows D5M_FRAME_GEN_LFSR_EN the same way the design does.
`timescale 1ns/1ps

module tb_d5m_frame_gen;

    localparam int DW       = 12;
    localparam int W        = 8;
    localparam int H        = 4;
    localparam int HB       = 3;
    localparam int VB       = 5;
    localparam int LEAD     = 2;
    localparam int LINE_LEN = W + HB;
    localparam int FV_HI    = LEAD + H * LINE_LEN;   // 46
    localparam int PERIOD   = FV_HI + VB;            // 51
    localparam int MASK     = (1 << DW) - 1;

    logic          pixclk = 1'b0;
    logic          reset;
    logic          enable;
    logic [1:0]    pattern_sel;
    logic          ifval;
    logic          ilval;
    logic [DW-1:0] idata;
    logic [15:0]   frame_count;
    logic          busy;

    int vectors     = 0;
    int miscompares = 0;
    bit checking    = 0;

    d5m_frame_gen dut (
        .pixclk      (pixclk),
        .reset       (reset),
        .enable      (enable),
        .pattern_sel (pattern_sel),
        .ifval       (ifval),
        .ilval       (ilval),
        .idata       (idata),
        .frame_count (frame_count),
        .busy        (busy)
    );

    always #5 pixclk = ~pixclk;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge pixclk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic logic [15:0] lfsr_after(input int n);
        logic [15:0] s;
        s = 16'hACE1;
        for (int i = 0; i < n; i++) s = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
        return s;
    endfunction

    function automatic int exp_pixel(input int pat, input int col, input int ln);
        int v;
        case (pat)
            0: v = col & MASK;
            1: v = ln & MASK;
            2: begin
                if (ln % 2 == 0) v = (col % 2 == 0) ? (1 << (DW - 1)) : MASK;
                else             v = (col % 2 == 0) ? 0 : (1 << (DW - 1));
            end
            default: begin
`ifdef D5M_FRAME_GEN_LFSR_EN
                v = int'(lfsr_after(ln * W + col)) & MASK;
`else
                v = 0;
`endif
            end
        endcase
        return v;
    endfunction

    // Model: a frame is a position 0..PERIOD-1; outputs after an edge describe
    // the position held before that edge.
    bit          m_active = 0;
    int          m_pos    = 0;
    int          m_pat    = 0;
    bit          e_ifval  = 0;
    bit          e_ilval  = 0;
    int          e_idata  = 0;
    bit          e_busy   = 0;
    logic [15:0] e_fc     = 16'd0;

    always @(posedge pixclk or posedge reset) begin : model
        int q, ln, col;
        if (reset) begin
            m_active <= 0;
            m_pos    <= 0;
            m_pat    <= 0;
            e_ifval  <= 0;
            e_ilval  <= 0;
            e_idata  <= 0;
            e_busy   <= 0;
            e_fc     <= 16'd0;
        end else begin
            e_busy  <= m_active;
            e_ifval <= m_active && (m_pos < FV_HI);
            e_ilval <= 0;
            e_idata <= 0;
            if (m_active && m_pos >= LEAD && m_pos < FV_HI) begin
                q   = m_pos - LEAD;
                ln  = q / LINE_LEN;
                col = q % LINE_LEN;
                if (col < W) begin
                    e_ilval <= 1;
                    e_idata <= exp_pixel(m_pat, col, ln);
                end
            end
            if (m_active && m_pos == FV_HI) e_fc <= e_fc + 16'd1;
            if (!m_active) begin
                if (enable) begin
                    m_active <= 1;
                    m_pos    <= 0;
                    m_pat    <= int'(pattern_sel);
                end
            end else if (m_pos == PERIOD - 1) begin
                if (enable) begin
                    m_pos <= 0;
                    m_pat <= int'(pattern_sel);
                end else begin
                    m_active <= 0;
                end
            end else begin
                m_pos <= m_pos + 1;
            end
        end
    end

    // Compare every cycle against the model.
    always @(negedge pixclk) begin
        if (checking) begin
            check("ifval", int'(ifval), int'(e_ifval));
            check("ilval", int'(ilval), int'(e_ilval));
            check("idata", int'(idata), e_idata);
            check("busy", int'(busy), int'(e_busy));
            check("frame_count", int'(frame_count), int'(e_fc));
        end
    end

    // ---------------- frame capture monitor ----------------
    int            rises       = 0;
    int            frames_done = 0;
    int            hi_len      = 0;
    int            lo_len      = 0;
    int            last_hi     = 0;
    int            last_lo     = 0;
    int            mon_line    = -1;
    int            mon_col     = 0;
    logic          prev_ifval  = 0;
    logic          prev_ilval  = 0;
    logic [DW-1:0] cap [0:H-1][0:W-1];

    always @(negedge pixclk) begin
        if (ifval) begin
            if (!prev_ifval) begin
                rises    <= rises + 1;
                if (frames_done > 0) last_lo <= lo_len;
                hi_len   <= 1;
                mon_line <= -1;
            end else begin
                hi_len <= hi_len + 1;
            end
        end else begin
            if (prev_ifval) begin
                last_hi     <= hi_len;
                frames_done <= frames_done + 1;
                lo_len      <= 1;
            end else begin
                lo_len <= lo_len + 1;
            end
        end
        if (ilval) begin
            if (!prev_ilval) begin
                mon_line <= mon_line + 1;
                mon_col  <= 1;
                if (mon_line + 1 >= 0 && mon_line + 1 < H) cap[mon_line + 1][0] <= idata;
            end else begin
                mon_col <= mon_col + 1;
                if (mon_line >= 0 && mon_line < H && mon_col < W) cap[mon_line][mon_col] <= idata;
            end
        end
        prev_ifval <= ifval;
        prev_ilval <= ilval;
    end

    task automatic wait_frames(input int target);
        int n = 0;
        while (frames_done < target && n < 3000) begin
            tick();
            n++;
        end
        check("frames_done", frames_done, target);
    endtask

    task automatic wait_line(input int rise_target, input int line_target);
        int n = 0;
        while (!(rises >= rise_target && mon_line >= line_target) && n < 3000) begin
            tick();
            n++;
        end
        check("line_reached", mon_line, line_target);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        reset       = 1'b1;
        enable      = 1'b0;
        pattern_sel = 2'd0;
        repeat (3) tick();
        check("rst_ifval", int'(ifval), 0);
        check("rst_ilval", int'(ilval), 0);
        check("rst_idata", int'(idata), 0);
        check("rst_fc", int'(frame_count), 0);
        check("rst_busy", int'(busy), 0);
        checking = 1;
        reset    = 1'b0;
        tick();
        check("idle_busy", int'(busy), 0);

        // x-ramp, enable held: three frames.
        enable = 1'b1;
        wait_frames(3);
        check("x_hi_len", last_hi, 46);
        check("x_lo_len", last_lo, 5);
        check("x_fc3", int'(frame_count), 3);
        check("x_px00", int'(cap[0][0]), 0);
        check("x_px07", int'(cap[0][7]), 7);
        check("x_px34", int'(cap[3][4]), 4);

        // y-ramp frame, switched to x-ramp mid-frame.
        pattern_sel = 2'd1;
        wait_line(4, 1);
        pattern_sel = 2'd0;
        wait_frames(4);
        check("y_px05", int'(cap[0][5]), 0);
        check("y_px10", int'(cap[1][0]), 1);
        check("y_px27", int'(cap[2][7]), 2);
        check("y_px33", int'(cap[3][3]), 3);
        wait_frames(5);
        check("next_px16", int'(cap[1][6]), 6);
        check("next_px32", int'(cap[3][2]), 2);

        // Bayer GRBG.
        pattern_sel = 2'd2;
        wait_frames(6);
        check("bayer_00", int'(cap[0][0]), 'h800);
        check("bayer_01", int'(cap[0][1]), 'hFFF);
        check("bayer_10", int'(cap[1][0]), 'h000);
        check("bayer_11", int'(cap[1][1]), 'h800);
        check("bayer_21", int'(cap[2][1]), 'hFFF);

        // LFSR pattern over two frames.
        pattern_sel = 2'd3;
        wait_frames(7);
`ifdef D5M_FRAME_GEN_LFSR_EN
        check("lfsr_f1_p0", int'(cap[0][0]), 'hCE1);
        check("lfsr_f1_p1", int'(cap[0][1]), 'h670);
`else
        check("lfsr_off_p0", int'(cap[0][0]), 0);
        check("lfsr_off_p37", int'(cap[3][7]), 0);
`endif
        wait_frames(8);
`ifdef D5M_FRAME_GEN_LFSR_EN
        check("lfsr_f2_p0", int'(cap[0][0]), 'hCE1);
        check("lfsr_f2_p1", int'(cap[0][1]), 'h670);
`else
        check("lfsr_off_f2", int'(cap[1][3]), 0);
`endif

        // Drop enable during line 1: the frame still completes.
        pattern_sel = 2'd0;
        wait_line(9, 1);
        enable = 1'b0;
        wait_frames(9);
        check("stop_hi_len", last_hi, 46);
        check("stop_fc", int'(frame_count), 9);
        check("stop_busy_fall", int'(busy), 1);
        repeat (4) tick();
        check("stop_busy_vb", int'(busy), 1);
        tick();
        check("stop_busy_idle", int'(busy), 0);
        repeat (60) tick();
        check("stop_no_rise", rises, 9);
        check("stop_ifval", int'(ifval), 0);

        // Reset during line 2 of a running frame.
        enable = 1'b1;
        wait_line(10, 2);
        repeat (3) tick();
        check("pre_rst_ilval", int'(ilval), 1);
        #2 reset = 1'b1;
        #1;
        check("async_ifval", int'(ifval), 0);
        check("async_ilval", int'(ilval), 0);
        check("async_idata", int'(idata), 0);
        check("async_fc", int'(frame_count), 0);
        check("async_busy", int'(busy), 0);
        tick();
        tick();
        reset = 1'b0;
        wait_frames(11);
        check("restart_hi_len", last_hi, 46);
        check("restart_fc", int'(frame_count), 1);
        check("restart_px00", int'(cap[0][0]), 0);
        check("restart_px24", int'(cap[2][4]), 4);
        check("restart_px37", int'(cap[3][7]), 7);

        enable = 1'b0;
        repeat (20) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
